crc_port_arbiter: RTL
=====================

// Module: crc_port_arbiter
// PURPOSE
// Packet-granular round-robin arbiter sharing one CRC_Check instance between NUM_PORTS write ports.
// Grants one port a whole packet (sop..eop), forwards it registered to the checker, samples crc_valid,
// then returns a per-packet pass/fail report tagged with the port index. Sits in front of SRAMC write path.
// PARAMETERS
// NUM_PORTS   4    number of requesting write ports (2..8)
// PORT_W      2    width of port index, = clog2(NUM_PORTS)
// DATA_WIDTH  8    byte width of wr_data bus
// CRC_LAT     1    cycles after forwarded eop at which crc_valid is sampled (1..7)
// MAX_LEN     64   max cycles from granted sop to eop before abort (timeout feature only)
// PORTS
// clk          in   1                    system clock
// rst_n        in   1                    synchronous reset, active low
// req          in   NUM_PORTS            per-port packet request, held until gnt
// in_sop       in   NUM_PORTS            per-port start of packet
// in_eop       in   NUM_PORTS            per-port end of packet
// in_valid     in   NUM_PORTS            per-port data valid
// in_data      in   NUM_PORTS*DATA_WIDTH per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
// gnt          out  NUM_PORTS            one-hot grant, held for the whole packet
// wr_sop       out  1                    to CRC_Check
// wr_eop       out  1                    to CRC_Check
// wr_valid     out  1                    to CRC_Check
// wr_data      out  DATA_WIDTH           to CRC_Check
// crc_valid    in   1                    CRC result from CRC_Check (1 = packet CRC correct)
// rpt_valid    out  1                    one-cycle report strobe
// rpt_port     out  PORT_W               port index of reported packet
// rpt_ok       out  1                    1 = CRC pass
// rpt_timeout  out  1                    1 = packet aborted by timeout
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): all outputs 0, state IDLE, rr pointer 0, counters 0; applies mid-packet too.
// - FSM: IDLE -> GRANT -> WAIT -> REPORT -> IDLE.
// - IDLE: if req!=0, pick first requesting port searching from ptr upward (wrap at NUM_PORTS-1 -> 0);
//   register gnt one-hot, latch port index, go GRANT. req==0: stay, gnt=0.
// - GRANT: gnt held. wr_* = granted port's in_* delayed one register (1-cycle latency); non-granted ports ignored.
//   Granted port must present in_sop in the first gnt cycle; in_sop/in_valid before gnt are ignored.
//   in_eop sampled on granted port -> next cycle gnt=0, state WAIT; wr_eop goes out that same cycle.
// - WAIT: wr_* = 0; count CRC_LAT cycles from the wr_eop cycle; at count==CRC_LAT sample crc_valid, go REPORT.
// - REPORT: rpt_valid=1 for exactly one cycle with rpt_port=latched index, rpt_ok=sampled crc_valid;
//   ptr <= granted index+1 (mod NUM_PORTS); go IDLE. Back-to-back packets: min 1 IDLE cycle between grants.
// - rpt_port/rpt_ok/rpt_timeout hold last value when rpt_valid=0; reset to 0.
// - Single requester continuously asserting req is regranted every packet; requester dropping req in GRANT
//   has no effect (packet ends only on eop or timeout).
// - gnt never has more than one bit set; gnt and rpt_valid never high in the same cycle.
// CONFIGURATION
// - CRC_ARB_TIMEOUT_EN defined: GRANT counts cycles from first gnt cycle; if no in_eop by count==MAX_LEN,
//   arbiter forces wr_eop=1 for one cycle, drops gnt, skips WAIT, reports rpt_ok=0, rpt_timeout=1.
//   in_eop on the same cycle as count==MAX_LEN wins (normal end, no timeout).
// - Not defined: no counter, GRANT waits indefinitely for eop; rpt_timeout tied 0.
// TESTING
// - Reset then req=4'b0001, port0 sends sop+3 bytes+CRC byte+eop, crc_valid=1 -> gnt=0001, wr_* lag 1 cycle,
//   rpt_valid pulse, rpt_port=0, rpt_ok=1.
// - req=4'b1111 held, four packets -> grant order 0,1,2,3,0; each rpt_port matches grant order.
// - ptr=2 after port1 report, req=4'b0011 -> next gnt=0001 (wrap-around), never 0010 first.
// - Port2 packet with corrupted CRC byte (crc_valid=0 at sample) -> rpt_port=2, rpt_ok=0, rpt_timeout=0.
// - CRC_ARB_TIMEOUT_EN, MAX_LEN=8, port3 never asserts eop -> wr_eop forced at cycle 8, rpt_port=3,
//   rpt_ok=0, rpt_timeout=1; next req serviced normally.
// - rst_n=0 for one cycle mid-GRANT on port1 -> all outputs 0 next cycle, ptr=0, req=4'b0110 then grants port1.

Source files
------------

// File: rtl/crc_port_arbiter.sv
// crc_port_arbiter: packet-granular round-robin arbiter sharing one CRC_Check between NUM_PORTS write ports.
// Define CRC_ARB_TIMEOUT_EN to abort packets whose eop does not arrive within MAX_LEN grant cycles.
module crc_port_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int PORT_W     = 2,
   parameter int DATA_WIDTH = 8,
   parameter int CRC_LAT    = 1,
   parameter int MAX_LEN    = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req,
   input  logic [NUM_PORTS-1:0]             in_sop,
   input  logic [NUM_PORTS-1:0]             in_eop,
   input  logic [NUM_PORTS-1:0]             in_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
   output logic [NUM_PORTS-1:0]             gnt,
   output logic                             wr_sop,
   output logic                             wr_eop,
   output logic                             wr_valid,
   output logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             crc_valid,
   output logic                             rpt_valid,
   output logic [PORT_W-1:0]                rpt_port,
   output logic                             rpt_ok,
   output logic                             rpt_timeout
);
   localparam int CW = $clog2(MAX_LEN + 8);
   localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2, REPORT = 2'd3;
   logic [1:0]        state;
   logic [PORT_W-1:0] ptr, idx, pick;
   logic [CW-1:0]     cnt;
   // scan downward so the requester closest above ptr is the last (winning) assignment
   always_comb begin
      pick = ptr;
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NUM_PORTS]) pick = PORT_W'((int'(ptr) + i) % NUM_PORTS);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         idx         <= '0;
         cnt         <= '0;
         gnt         <= '0;
         wr_sop      <= 1'b0;
         wr_eop      <= 1'b0;
         wr_valid    <= 1'b0;
         wr_data     <= '0;
         rpt_valid   <= 1'b0;
         rpt_port    <= '0;
         rpt_ok      <= 1'b0;
         rpt_timeout <= 1'b0;
      end else begin
         wr_sop    <= 1'b0;
         wr_eop    <= 1'b0;
         wr_valid  <= 1'b0;
         wr_data   <= '0;
         rpt_valid <= 1'b0;
         case (state)
            IDLE: if (|req) begin
               gnt   <= NUM_PORTS'(1) << pick;
               idx   <= pick;
               cnt   <= CW'(1);
               state <= GRANT;
            end
            GRANT: begin
               wr_sop   <= in_sop[idx];
               wr_eop   <= in_eop[idx];
               wr_valid <= in_valid[idx];
               wr_data  <= in_data[idx*DATA_WIDTH +: DATA_WIDTH];
               cnt      <= cnt + 1'b1;
               if (in_eop[idx]) begin
                  gnt   <= '0;
                  cnt   <= '0;
                  state <= WAIT;
               end
`ifdef CRC_ARB_TIMEOUT_EN
               else if (cnt == CW'(MAX_LEN)) begin
                  gnt         <= '0;
                  wr_eop      <= 1'b1;
                  rpt_valid   <= 1'b1;
                  rpt_port    <= idx;
                  rpt_ok      <= 1'b0;
                  rpt_timeout <= 1'b1;
                  state       <= REPORT;
               end
`endif
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(CRC_LAT)) begin
                  rpt_valid   <= 1'b1;
                  rpt_port    <= idx;
                  rpt_ok      <= crc_valid;
                  rpt_timeout <= 1'b0;
                  state       <= REPORT;
               end
            end
            default: begin
               ptr   <= (idx == PORT_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
